// File: rtl/wm_panel_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : wm_panel_ctrl_if
// Description : Link between the front-panel conditioner and the wash FSM.
//               It carries the start command, the latched program, the
//               debounced door and soap status, the lock drive and the reject
//               report. The panel side uses the master modport; the wash FSM
//               uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface wm_panel_ctrl_if;
  logic       program_done;
  logic       start;
  logic [2:0] program_selection;
  logic       doorclosed;
  logic       soap;
  logic       door_lock;
  logic       busy;
  logic       start_reject;
  logic [1:0] reject_code;

  modport master (
    input  program_done,
    output start, program_selection, doorclosed, soap,
    output door_lock, busy, start_reject, reject_code
  );

  modport slave (
    output program_done,
    input  start, program_selection, doorclosed, soap,
    input  door_lock, busy, start_reject, reject_code
  );
endinterface
`default_nettype wire

// File: rtl/wm_panel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wm_panel_ctrl
// Description : Front-panel input conditioner for the washing machine. It
//               synchronises and debounces start/door/soap, validates and
//               latches the program code, and issues a one-cycle start pulse.
//               It drives the door-lock solenoid from program start until a
//               fixed hold time after program_done.
//               Optional macro PANEL_SOAP_CHECK_EN: refuse programs 000/001
//               when no soap is detected (reject_code 11).
// Revision    : 1.0 - initial release
// ============================================================================
module wm_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int UNLOCK_CYCLES   = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       power,
  input  wire logic       start_btn,
  input  wire logic       door_sw,
  input  wire logic       soap_sw,
  input  wire logic [2:0] prog_sel_in,
  wm_panel_ctrl_if.master fsm
);

  localparam logic [7:0] c_deb_last    = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] c_unlock_load = 8'(UNLOCK_CYCLES);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_RUN    = 2'd2,
    ST_UNLOCK = 2'd3
  } state_t;

  // Bit 0 = start button, bit 1 = door switch, bit 2 = soap sensor.
  logic [2:0] w_raw;
  logic [2:0] w_deb;
  assign w_raw = {soap_sw, door_sw, start_btn};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      logic       r_s1;
      logic       r_s2;
      logic       r_d;
      logic [7:0] r_cnt;

      // Two-flop synchroniser followed by a stability counter; the debounced
      // value only follows once the synced input differs for DEBOUNCE_CYCLES.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s1  <= 1'b0;
          r_s2  <= 1'b0;
          r_d   <= 1'b0;
          r_cnt <= 8'd0;
        end else begin
          r_s1 <= w_raw[gi];
          r_s2 <= r_s1;
          if (r_s2 == r_d) begin
            r_cnt <= 8'd0;
          end else if (r_cnt == c_deb_last) begin
            r_d   <= r_s2;
            r_cnt <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      end

      assign w_deb[gi] = r_d;
    end
  endgenerate

  logic       r_start_prev;
  logic       w_start_rise;
  state_t     r_state,  w_state_nxt;
  logic       r_start,  w_start_nxt;
  logic [2:0] r_sel,    w_sel_nxt;
  logic       r_lock,   w_lock_nxt;
  logic       r_busy,   w_busy_nxt;
  logic       r_rej,    w_rej_nxt;
  logic [1:0] r_code,   w_code_nxt;
  logic [7:0] r_ucnt,   w_ucnt_nxt;

  assign w_start_rise = w_deb[0] & ~r_start_prev;

  // Next-state and next-output decisions; power loss overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = 1'b0;
    w_sel_nxt   = r_sel;
    w_lock_nxt  = r_lock;
    w_busy_nxt  = r_busy;
    w_rej_nxt   = 1'b0;
    w_code_nxt  = 2'b00;
    w_ucnt_nxt  = r_ucnt;
    if (!power) begin
      w_state_nxt = ST_OFF;
      w_sel_nxt   = 3'b000;
      w_lock_nxt  = 1'b0;
      w_busy_nxt  = 1'b0;
      w_ucnt_nxt  = 8'd0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          if (w_start_rise) begin
            if (prog_sel_in[2]) begin
              w_rej_nxt  = 1'b1;
              w_code_nxt = 2'b01;
            end else if (!w_deb[1]) begin
              w_rej_nxt  = 1'b1;
              w_code_nxt = 2'b10;
`ifdef PANEL_SOAP_CHECK_EN
            end else if (!prog_sel_in[1] && !w_deb[2]) begin
              w_rej_nxt  = 1'b1;
              w_code_nxt = 2'b11;
`endif
            end else begin
              w_state_nxt = ST_RUN;
              w_start_nxt = 1'b1;
              w_sel_nxt   = prog_sel_in;
              w_lock_nxt  = 1'b1;
              w_busy_nxt  = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (fsm.program_done) begin
            w_state_nxt = ST_UNLOCK;
            w_ucnt_nxt  = c_unlock_load;
          end
        end
        ST_UNLOCK: begin
          if (r_ucnt == 8'd1) begin
            w_state_nxt = ST_IDLE;
            w_lock_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_ucnt_nxt  = 8'd0;
          end else begin
            w_ucnt_nxt = r_ucnt - 8'd1;
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_OFF;
      r_start_prev <= 1'b0;
      r_start      <= 1'b0;
      r_sel        <= 3'b000;
      r_lock       <= 1'b0;
      r_busy       <= 1'b0;
      r_rej        <= 1'b0;
      r_code       <= 2'b00;
      r_ucnt       <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_start_prev <= w_deb[0];
      r_start      <= w_start_nxt;
      r_sel        <= w_sel_nxt;
      r_lock       <= w_lock_nxt;
      r_busy       <= w_busy_nxt;
      r_rej        <= w_rej_nxt;
      r_code       <= w_code_nxt;
      r_ucnt       <= w_ucnt_nxt;
    end
  end

  assign fsm.start             = r_start;
  assign fsm.program_selection = r_sel;
  assign fsm.doorclosed        = w_deb[1];
  assign fsm.soap              = w_deb[2];
  assign fsm.door_lock         = r_lock;
  assign fsm.busy              = r_busy;
  assign fsm.start_reject      = r_rej;
  assign fsm.reject_code       = r_code;

endmodule
`default_nettype wire

// File: tb/tb_wm_panel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wm_panel_ctrl
// Description : Directed self-checking bench for wm_panel_ctrl with
//               DEBOUNCE_CYCLES=4 and UNLOCK_CYCLES=8. Expectations for the
//               soap check follow PANEL_SOAP_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wm_panel_ctrl;

  logic       clk;
  logic       rst;
  logic       power;
  logic       start_btn;
  logic       door_sw;
  logic       soap_sw;
  logic [2:0] prog_sel_in;

  int n_checks;
  int n_errors;

  wm_panel_ctrl_if bus ();

  wm_panel_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .UNLOCK_CYCLES  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .power      (power),
    .start_btn  (start_btn),
    .door_sw    (door_sw),
    .soap_sw    (soap_sw),
    .prog_sel_in(prog_sel_in),
    .fsm        (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Button goes down at a negedge; start/reject become visible 7 edges later
  // (2 sync + 4 debounce + 1 output register).
  task automatic press(input logic [2:0] code);
    prog_sel_in = code;
    start_btn   = 1'b1;
    tick(7);
  endtask

  task automatic release_btn();
    start_btn = 1'b0;
    tick(8);
  endtask

  initial begin
    int n_pulse;
    int first_i;
    int lock_cnt;
    n_checks         = 0;
    n_errors         = 0;
    rst              = 1'b1;
    power            = 1'b0;
    start_btn        = 1'b0;
    door_sw          = 1'b0;
    soap_sw          = 1'b0;
    prog_sel_in      = 3'b000;
    bus.program_done = 1'b0;
    tick(2);

    // Reset state
    check("rst_start",  32'(bus.start), 0);
    check("rst_sel",    32'(bus.program_selection), 0);
    check("rst_door",   32'(bus.doorclosed), 0);
    check("rst_lock",   32'(bus.door_lock), 0);
    check("rst_busy",   32'(bus.busy), 0);
    check("rst_rej",    32'(bus.start_reject), 0);
    check("rst_code",   32'(bus.reject_code), 0);
    rst = 1'b0;
    tick(2);

    // Door switch with 3-cycle glitches, then a clean step
    for (int g = 0; g < 2; g++) begin
      door_sw = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick(1);
        check("glitch_hi", 32'(bus.doorclosed), 0);
      end
      door_sw = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick(1);
        check("glitch_lo", 32'(bus.doorclosed), 0);
      end
    end
    door_sw = 1'b1;
    soap_sw = 1'b1;
    tick(5);
    check("door_before6", 32'(bus.doorclosed), 0);
    tick(1);
    check("door_at6", 32'(bus.doorclosed), 1);
    check("soap_at6", 32'(bus.soap), 1);

    // Power up, OFF -> IDLE
    power = 1'b1;
    tick(1);
    check("idle_busy", 32'(bus.busy), 0);

    // Held press for 50 cycles gives exactly one start pulse
    prog_sel_in = 3'b001;
    start_btn   = 1'b1;
    n_pulse     = 0;
    first_i     = 0;
    for (int i = 1; i <= 50; i++) begin
      tick(1);
      if (bus.start) begin
        n_pulse++;
        if (first_i == 0) first_i = i;
      end
    end
    check("start_pulses", 32'(n_pulse), 1);
    check("start_latency", 32'(first_i), 7);
    check("run_sel",  32'(bus.program_selection), 3'b001);
    check("run_lock", 32'(bus.door_lock), 1);
    check("run_busy", 32'(bus.busy), 1);
    release_btn();

    // program_done -> UNLOCK for 8 cycles, then IDLE
    bus.program_done = 1'b1;
    tick(1);
    bus.program_done = 1'b0;
    check("unlock_busy", 32'(bus.busy), 1);
    lock_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.door_lock) lock_cnt++;
      tick(1);
    end
    check("unlock_len", 32'(lock_cnt), 8);
    check("after_lock", 32'(bus.door_lock), 0);
    check("after_busy", 32'(bus.busy), 0);
    check("after_sel",  32'(bus.program_selection), 3'b001);

    // Invalid program code
    press(3'b101);
    check("inv_rej",   32'(bus.start_reject), 1);
    check("inv_code",  32'(bus.reject_code), 2'b01);
    check("inv_start", 32'(bus.start), 0);
    check("inv_sel",   32'(bus.program_selection), 3'b001);
    tick(1);
    check("inv_rej_end",  32'(bus.start_reject), 0);
    check("inv_code_end", 32'(bus.reject_code), 0);
    release_btn();

    // Door open
    door_sw = 1'b0;
    tick(8);
    check("door_open", 32'(bus.doorclosed), 0);
    press(3'b000);
    check("door_rej",   32'(bus.start_reject), 1);
    check("door_code",  32'(bus.reject_code), 2'b10);
    check("door_start", 32'(bus.start), 0);
    tick(1);
    check("door_rej_end", 32'(bus.start_reject), 0);
    release_btn();
    door_sw = 1'b1;
    tick(8);

    // No soap
    soap_sw = 1'b0;
    tick(8);
    check("soap_gone", 32'(bus.soap), 0);
    press(3'b000);
`ifdef PANEL_SOAP_CHECK_EN
    check("soap_rej",   32'(bus.start_reject), 1);
    check("soap_code",  32'(bus.reject_code), 2'b11);
    check("soap_start", 32'(bus.start), 0);
    release_btn();
    press(3'b011);
    check("soap011_start", 32'(bus.start), 1);
    check("soap011_sel",   32'(bus.program_selection), 3'b011);
`else
    check("nosoap_rej",   32'(bus.start_reject), 0);
    check("nosoap_start", 32'(bus.start), 1);
    check("nosoap_sel",   32'(bus.program_selection), 3'b000);
`endif
    release_btn();

    // Power loss wins over simultaneous program_done
    power            = 1'b0;
    bus.program_done = 1'b1;
    tick(1);
    bus.program_done = 1'b0;
    check("pwr_lock", 32'(bus.door_lock), 0);
    check("pwr_busy", 32'(bus.busy), 0);
    check("pwr_sel",  32'(bus.program_selection), 0);
    power = 1'b1;
    tick(1);
    check("pwr_idle_busy", 32'(bus.busy), 0);

    // Start again, enter UNLOCK, then asynchronous reset mid-cycle
    press(3'b010);
    check("p2_start", 32'(bus.start), 1);
    check("p2_sel",   32'(bus.program_selection), 3'b010);
    release_btn();
    bus.program_done = 1'b1;
    tick(1);
    bus.program_done = 1'b0;
    tick(3);
    check("mid_unlock_lock", 32'(bus.door_lock), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_lock", 32'(bus.door_lock), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_sel",  32'(bus.program_selection), 0);
    check("arst_door", 32'(bus.doorclosed), 0);
    check("arst_soap", 32'(bus.soap), 0);
    check("arst_code", 32'(bus.reject_code), 0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
